spi_slave_rx_tx: RTL and testbench
==================================

Name: spi_slave_rx_tx

Overview:
- SPI slave endpoint that talks to our SPI master over the CS/SCLK/MOSI/MISO link.
- Receives MOSI frames MSB-first into rx_data_o with a valid/ack handshake. Transmits tx_data_i MSB-first on MISO.
- Mode 0 only (CPOL=0, CPHA=0): samples on SCLK rising edge, drives MISO on falling edge.
- Runs entirely in the SCLK domain. Serves as the bench/FPGA counterpart of the master and as the slave side of board-level loopback.

Parameters:
- F_NUM, 1, frames per CS-low transaction.
- F_SIZE, 8, bits per frame; F_SIZE >= 2.
- C_SIZE, $clog2(F_SIZE), bit counter width.
- N_SIZE, $clog2(F_NUM+1), frame counter width.

Ports:
- rst  in  1  reset; asynchronous, active-high.
- SCLK  in  1  clock; SPI serial clock from master.
- CS  in  1  chip select, active-low. Deassertion (high) is an asynchronous frame resync.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- tx_data_i  in  F_SIZE  word to transmit in the next frame.
- tx_req_o  out  1  high while the block is at a frame boundary (bit_cnt == F_SIZE-1); tx_data_i must be stable.
- rx_data_o  out  F_SIZE  last completed received frame.
- rx_valid_o  out  1  rx_data_o holds an unacknowledged frame.
- rx_ack_i  in  1  consumer acknowledge, sampled on SCLK rising edge.
- overrun_o  out  1  sticky: a frame completed while rx_valid_o=1 and no ack was given.
- frame_cnt_o  out  N_SIZE  frames completed in the current transaction.
- busy_o  out  1  high in SHIFT state.

Behaviour:
- Reset (rst=1, async), all outputs and state cleared:
  - state=IDLE, bit_cnt=F_SIZE-1, frame_cnt_o=0.
  - rx_data_o=0, rx_valid_o=0, overrun_o=0, miso_q=0.
  - tx_req_o=1, busy_o=0.
- CS=1 (async), forces state=IDLE, bit_cnt=F_SIZE-1, frame_cnt_o=0.
  - Does not touch rx_data_o, rx_valid_o or overrun_o.
  - A partial frame is discarded silently; no rx_valid_o.
- FSM, advanced on SCLK rising edge with CS=0:
  - IDLE: sample MOSI into rx_shift[F_SIZE-1]; capture tx_word<=tx_data_i; bit_cnt<=F_SIZE-2; go SHIFT.
  - SHIFT, bit_cnt>0: rx_shift[bit_cnt]<=MOSI; bit_cnt<=bit_cnt-1. If bit_cnt==F_SIZE-1, also capture tx_word<=tx_data_i.
  - SHIFT, bit_cnt==0 (frame complete):
    - rx_data_o<={rx_shift[F_SIZE-1:1],MOSI}; rx_valid_o<=1; frame_cnt_o<=frame_cnt_o+1; bit_cnt<=F_SIZE-1.
    - If frame_cnt_o+1==F_NUM, go DONE; else stay SHIFT.
  - DONE: extra SCLK edges are ignored (no sampling, counters frozen). Only CS=1 returns to IDLE.
- MISO:
  - In IDLE: MISO = tx_data_i[F_SIZE-1], combinational, so the first bit is valid before the first rising edge.
  - Otherwise MISO = miso_q.
  - On SCLK falling edge with CS=0:
    - SHIFT, bit_cnt==F_SIZE-1: miso_q<=tx_data_i[F_SIZE-1].
    - SHIFT, other bit_cnt: miso_q<=tx_word[bit_cnt].
    - DONE: miso_q<=0.
- Receive handshake, evaluated on the rising edge:
  - Frame completion has priority over ack: completion with rx_ack_i=1 leaves rx_valid_o=1 with the new data.
  - Completion with rx_valid_o=1 and rx_ack_i=0: overrun_o<=1 (sticky until rst); rx_data_o is overwritten.
  - rx_ack_i=1 without completion: rx_valid_o<=0.
- Latency: rx_valid_o rises on the F_SIZE-th rising edge of a frame.
- Width: frame_cnt_o counts 0..F_NUM and never wraps within a transaction.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: every tx_data_i capture (tx_word load, IDLE MISO mux, frame-boundary miso_q load) uses rx_data_o instead. The slave echoes the previous received frame; the first frame after rst echoes 0. tx_data_i is ignored and tx_req_o is still generated.
- Undefined: transmit source is tx_data_i as described above.

Test Plan:
- F_SIZE=8, F_NUM=1; master sends 0xA5, tx_data_i=0x3C -> after 8 rising edges: rx_data_o=0xA5, rx_valid_o=1, frame_cnt_o=1; master receives 0x3C; busy_o=0.
- F_NUM=2; MOSI 0x12 then 0x34, tx_data_i changed 0x81->0x7E while tx_req_o=1 between frames, no ack -> rx_data_o=0x34, overrun_o=1; master receives 0x81, 0x7E.
- Ack on the same edge as completion of frame 2 -> rx_valid_o stays 1, overrun_o=0, rx_data_o=frame 2.
- CS raised after 5 bits of 0xFF -> state IDLE, bit_cnt=7, rx_valid_o unchanged; next full frame 0x0F received correctly.
- rst asserted mid-frame (bit_cnt=3) -> all outputs at reset values immediately, without an SCLK edge.
- SPI_SLAVE_ECHO_EN defined; frames 0x55 then 0xC3 in one F_NUM=2 transaction -> MISO returns 0x00 then 0x55.

Source files
------------

// File: rtl/spi_slave_rx_tx_if.sv
// SPI link and receive-handshake signals of the mode-0 slave.
// The slave modport is the endpoint view; the master modport is the link partner / consumer view.
interface spi_slave_rx_tx_if #(
  parameter int unsigned F_SIZE = 8,
  parameter int unsigned N_SIZE = 1
);
  logic              CS;
  logic              MOSI;
  logic              MISO;
  logic [F_SIZE-1:0] tx_data_i;
  logic              tx_req_o;
  logic [F_SIZE-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ack_i;
  logic              overrun_o;
  logic [N_SIZE-1:0] frame_cnt_o;
  logic              busy_o;

  modport slave (
    input  CS, MOSI, tx_data_i, rx_ack_i,
    output MISO, tx_req_o, rx_data_o, rx_valid_o, overrun_o, frame_cnt_o, busy_o
  );

  modport master (
    output CS, MOSI, tx_data_i, rx_ack_i,
    input  MISO, tx_req_o, rx_data_o, rx_valid_o, overrun_o, frame_cnt_o, busy_o
  );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 slave: MSB-first receive with valid/ack handshake, MSB-first transmit, all in the SCLK domain.
// Optional SPI_SLAVE_ECHO_EN: transmit the previously received frame instead of tx_data_i.
module spi_slave_rx_tx #(
  parameter int unsigned F_NUM  = 1,
  parameter int unsigned F_SIZE = 8,
  parameter int unsigned C_SIZE = $clog2(F_SIZE),
  parameter int unsigned N_SIZE = $clog2(F_NUM + 1)
) (
  input logic              rst,
  input logic              SCLK,
  spi_slave_rx_tx_if.slave bus
);

  localparam logic [C_SIZE-1:0] BIT_LAST  = C_SIZE'(F_SIZE - 1);
  localparam logic [N_SIZE-1:0] FRAME_END = N_SIZE'(F_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [C_SIZE-1:0] r_bit_cnt;
  logic [N_SIZE-1:0] r_frame_cnt;
  logic [N_SIZE-1:0] w_frame_cnt_inc;
  logic [F_SIZE-1:1] r_rx_shift;
  logic [F_SIZE-2:0] r_tx_word;
  logic [F_SIZE-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overrun;
  logic              r_miso;
  logic [F_SIZE-1:0] w_tx_src;
  logic              w_clr;
  logic              w_sample;
  logic              w_frame_done;
  logic              w_boundary;

  // CS high is a frame resync: it clears the framing state like reset does
  assign w_clr           = rst | bus.CS;
  assign w_boundary      = (r_bit_cnt == BIT_LAST);
  assign w_frame_cnt_inc = r_frame_cnt + N_SIZE'(1);

`ifdef SPI_SLAVE_ECHO_EN
  logic w_unused_tx;
  assign w_tx_src    = r_rx_data;
  assign w_unused_tx = ^bus.tx_data_i;
`else
  assign w_tx_src = bus.tx_data_i;
`endif

  always_ff @(posedge SCLK or posedge w_clr) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sample     = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_sample    = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_sample = 1'b1;
        if (r_bit_cnt == '0) begin
          w_frame_done = 1'b1;
          if (w_frame_cnt_inc == FRAME_END) w_state_nxt = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  // Bit and frame counters; frozen in DONE because nothing is sampled there
  always_ff @(posedge SCLK or posedge w_clr) begin
    if (w_clr) begin
      r_bit_cnt   <= BIT_LAST;
      r_frame_cnt <= '0;
    end else if (w_frame_done) begin
      r_bit_cnt   <= BIT_LAST;
      r_frame_cnt <= w_frame_cnt_inc;
    end else if (w_sample) begin
      r_bit_cnt <= r_bit_cnt - C_SIZE'(1);
    end
  end

  // Receive shifter and transmit word; the last MOSI bit bypasses the shifter at completion
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      r_rx_shift <= '0;
      r_tx_word  <= '0;
    end else if (!bus.CS && w_sample) begin
      if (!w_frame_done) r_rx_shift[r_bit_cnt] <= bus.MOSI;
      if (w_boundary)    r_tx_word <= w_tx_src[F_SIZE-2:0];
    end
  end

  // Completion wins over ack; an unacked valid frame being overwritten is an overrun
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_frame_done) begin
      r_rx_data  <= {r_rx_shift, bus.MOSI};
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !bus.rx_ack_i) r_overrun <= 1'b1;
    end else if (bus.rx_ack_i) begin
      r_rx_valid <= 1'b0;
    end
  end

  // MISO launches on the falling edge so the master samples it stable on the next rise
  always_ff @(negedge SCLK or posedge rst) begin
    if (rst) begin
      r_miso <= 1'b0;
    end else if (!bus.CS) begin
      unique case (r_state)
        ST_SHIFT: r_miso <= w_boundary ? w_tx_src[F_SIZE-1] : r_tx_word[r_bit_cnt];
        ST_DONE:  r_miso <= 1'b0;
        default:  ;
      endcase
    end
  end

  assign bus.MISO        = (r_state == ST_IDLE) ? w_tx_src[F_SIZE-1] : r_miso;
  assign bus.tx_req_o    = w_boundary;
  assign bus.busy_o      = (r_state == ST_SHIFT);
  assign bus.rx_data_o   = r_rx_data;
  assign bus.rx_valid_o  = r_rx_valid;
  assign bus.overrun_o   = r_overrun;
  assign bus.frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Randomized bench for spi_slave_rx_tx acting as the SPI master and rx consumer,
// checked against a frame-level reference model.
module tb_spi_slave_rx_tx;

  localparam int unsigned F_NUM  = 2;
  localparam int unsigned F_SIZE = 8;
  localparam int unsigned N_SIZE = $clog2(F_NUM + 1);
  localparam int          HALF   = 10;
`ifdef SPI_SLAVE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic rst;
  logic SCLK;

  spi_slave_rx_tx_if #(.F_SIZE(F_SIZE), .N_SIZE(N_SIZE)) bus ();

  spi_slave_rx_tx #(.F_NUM(F_NUM), .F_SIZE(F_SIZE)) dut (
    .rst  (rst),
    .SCLK (SCLK),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: frame-level view of the receive side
  logic [F_SIZE-1:0] m_rx;
  bit                m_valid;
  bit                m_ovr;
  int                m_cnt;

  // Per-transaction stimulus; t_ack: 0 none, 1 ack on completion edge, 2 ack on first edge
  logic [F_SIZE-1:0] t_mosi [4];
  logic [F_SIZE-1:0] t_tx   [4];
  int                t_ack  [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [F_SIZE-1:0] exp_tx_word(input int f);
    return ECHO ? m_rx : t_tx[f];
  endfunction

  task automatic model_reset();
    m_rx    = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, ".rx_data"},  32'(bus.rx_data_o),  32'(m_rx));
    chk({tag, ".rx_valid"}, 32'(bus.rx_valid_o), 32'(m_valid));
    chk({tag, ".overrun"},  32'(bus.overrun_o),  32'(m_ovr));
  endtask

  task automatic chk_idle(input string tag, input logic [F_SIZE-1:0] txv);
    chk({tag, ".busy"},      32'(bus.busy_o),      32'(0));
    chk({tag, ".frame_cnt"}, 32'(bus.frame_cnt_o), 32'(0));
    chk({tag, ".tx_req"},    32'(bus.tx_req_o),    32'(1));
    chk({tag, ".miso"},      32'(bus.MISO),        32'(ECHO ? m_rx[F_SIZE-1] : txv[F_SIZE-1]));
  endtask

  task automatic do_frame(input int f);
    logic [F_SIZE-1:0] got;
    logic [F_SIZE-1:0] exp_w;
    bit                live;
    live  = (m_cnt < int'(F_NUM));
    exp_w = live ? exp_tx_word(f) : '0;
    for (int i = F_SIZE - 1; i >= 0; i--) begin
      bus.MOSI     = t_mosi[f][i];
      bus.rx_ack_i = (t_ack[f] == 2 && i == F_SIZE - 1) || (t_ack[f] == 1 && i == 0);
      #HALF;
      got[i] = bus.MISO;
      SCLK   = 1'b1;
      #1;
      if (i == F_SIZE - 1) begin
        chk("mid.tx_req", 32'(bus.tx_req_o), 32'(!live));
        chk("mid.busy",   32'(bus.busy_o),   32'(live));
      end
      if (i == 0) begin
        if (live) begin
          if (t_ack[f] == 2) m_valid = 1'b0;
          if (m_valid && t_ack[f] != 1) m_ovr = 1'b1;
          m_valid = 1'b1;
          m_rx    = t_mosi[f];
          m_cnt++;
        end
        chk_rx("frame");
        chk("frame.frame_cnt", 32'(bus.frame_cnt_o), 32'(m_cnt));
        chk("frame.busy",      32'(bus.busy_o),      32'(m_cnt < int'(F_NUM)));
        chk("frame.tx_req",    32'(bus.tx_req_o),    32'(1));
        chk("frame.miso_word", 32'(got),             32'(exp_w));
        if (f < 3) bus.tx_data_i = t_tx[f + 1];
      end
      #(HALF - 1);
      SCLK         = 1'b0;
      bus.rx_ack_i = 1'b0;
    end
  endtask

  task automatic run_txn(input int nf);
    m_cnt         = 0;
    bus.tx_data_i = t_tx[0];
    bus.CS        = 1'b0;
    #HALF;
    for (int f = 0; f < nf; f++) do_frame(f);
    #HALF;
    bus.CS = 1'b1;
    #1;
    chk_idle("txn_end", bus.tx_data_i);
    chk_rx("txn_end");
    #HALF;
  endtask

  task automatic abort_frame(input int nbits, input logic [F_SIZE-1:0] pat);
    logic [F_SIZE-1:0] txv;
    txv           = F_SIZE'($urandom);
    bus.tx_data_i = txv;
    bus.CS        = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = pat[F_SIZE - 1 - i];
      #HALF;
      SCLK = 1'b1;
      #HALF;
      SCLK = 1'b0;
    end
    #1;
    chk("abort.busy_pre", 32'(bus.busy_o), 32'(1));
    bus.CS = 1'b1;
    #1;
    chk_idle("abort", txv);
    chk_rx("abort");
    #HALF;
  endtask

  task automatic rst_mid(input int nbits);
    logic [F_SIZE-1:0] txv;
    txv           = F_SIZE'($urandom);
    bus.tx_data_i = txv;
    bus.CS        = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = 1'($urandom);
      #HALF;
      SCLK = 1'b1;
      #HALF;
      SCLK = 1'b0;
    end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk_idle("rst_mid", txv);
    chk_rx("rst_mid");
    #HALF;
    rst    = 1'b0;
    bus.CS = 1'b1;
    #HALF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #HALF;
    rst = 1'b0;
    model_reset();
    #HALF;
  endtask

  initial begin
    int nf;
    int kind;
    rst           = 1'b1;
    SCLK          = 1'b0;
    bus.CS        = 1'b1;
    bus.MOSI      = 1'b0;
    bus.rx_ack_i  = 1'b0;
    bus.tx_data_i = '0;
    model_reset();
    #HALF;
    chk_idle("reset", '0);
    chk_rx("reset");
    rst = 1'b0;
    #HALF;

    // Single frame
    t_mosi[0] = 8'hA5; t_tx[0] = 8'h3C; t_ack[0] = 0; t_tx[1] = 8'h00;
    run_txn(1);

    // Two frames, tx word changed at the boundary, no ack
    t_mosi[0] = 8'h12; t_mosi[1] = 8'h34; t_tx[0] = 8'h81; t_tx[1] = 8'h7E; t_tx[2] = 8'h00;
    t_ack[0] = 0; t_ack[1] = 0;
    run_txn(2);
    chk("t2.overrun", 32'(bus.overrun_o), 32'(1));

    // Ack coincident with completion of frame 2
    do_reset();
    t_ack[0] = 0; t_ack[1] = 1;
    run_txn(2);
    chk("t3.overrun", 32'(bus.overrun_o), 32'(0));

    // Partial frame discarded, then a clean frame
    abort_frame(5, 8'hFF);
    t_mosi[0] = 8'h0F; t_tx[0] = 8'hC6; t_ack[0] = 1;
    run_txn(1);

    // Reset in the middle of a frame
    rst_mid(4);

    // Two frames after reset (echo build returns 0x00 then 0x55)
    t_mosi[0] = 8'h55; t_mosi[1] = 8'hC3; t_tx[0] = 8'hAA; t_tx[1] = 8'h99; t_tx[2] = 8'h00;
    t_ack[0] = 0; t_ack[1] = 0;
    run_txn(2);

    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        abort_frame(int'($urandom_range(1, F_SIZE - 1)), F_SIZE'($urandom));
      end else if (kind == 1) begin
        rst_mid(int'($urandom_range(0, F_SIZE - 1)));
      end else begin
        nf = int'($urandom_range(1, 3));
        for (int f = 0; f < 4; f++) begin
          t_mosi[f] = F_SIZE'($urandom);
          t_tx[f]   = F_SIZE'($urandom);
          t_ack[f]  = (f < int'(F_NUM)) ? int'($urandom_range(0, 2)) : 0;
        end
        run_txn(nf);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
